// File: rtl/fp_div_pkg.sv
// Shared types and constants for the Newton-Raphson floating-point divider.
package fp_div_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_CLASSIFY, S_SEED, S_MUL_DX, S_SUB, S_MUL_X,
    S_QUOT, S_CORR, S_NORM, S_ROUND, S_OUT
  } state_e;

  typedef enum logic [1:0] {C_ZERO, C_NORM, C_INF, C_NAN} op_class_e;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  localparam fp_flags_t FP_FLAGS_NONE = 5'b00000;

  // Format constants are built in a wide word; callers keep the low W bits.
  localparam int unsigned FP_MAX_W = 128;
  localparam logic [FP_MAX_W-1:0] FP_ONE = 128'd1;

  function automatic logic [FP_MAX_W-1:0] fp_inf(input int unsigned exp_w, input int unsigned man_w);
    return ((FP_ONE << exp_w) - FP_ONE) << man_w;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    return fp_inf(exp_w, man_w) | (FP_ONE << (man_w - 32'd1));
  endfunction

endpackage

// File: rtl/fp_nr_divider_seed_lut.sv
// Reciprocal seed table: entry i holds 1/(1+(i+0.5)/2^LUT_BITS) in Q1.FW.
module fp_recip_seed_lut #(
  parameter int LUT_BITS = 10,
  parameter int FW       = 31
) (
  input  logic [LUT_BITS-1:0] idx,
  output logic [FW:0]         seed
);

  localparam int N  = 1 << LUT_BITS;
  localparam int NW = FW + LUT_BITS + 3;
  localparam logic [NW-1:0] NUM = {{(NW-1){1'b0}}, 1'b1} << (FW + LUT_BITS + 1);

  logic [FW:0] table_s [N];

  // 2^(FW+L+1) / (2^(L+1) + 2i + 1) is the midpoint reciprocal without fractions
  for (genvar i = 0; i < N; i++) begin : g_entry
    localparam logic [NW-1:0] DEN = NW'((32'd2 << LUT_BITS) + 32'd2 * i + 32'd1);
    localparam logic [NW-1:0] VAL = NUM / DEN;
    assign table_s[i] = VAL[FW:0];
  end

  assign seed = table_s[idx];

endmodule

// File: rtl/fp_nr_divider.sv
// IEEE-754 divider: LUT seed, NR_ITERS Newton-Raphson refinements, exact
// remainder correction and round-to-nearest-even, with valid/ready handshakes.
module fp_nr_divider
  import fp_div_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int NR_ITERS = 2,
  parameter int LUT_BITS = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1+EXP_W+MAN_W-1:0]   a,
  input  logic [1+EXP_W+MAN_W-1:0]   b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1+EXP_W+MAN_W-1:0]   result,
  output logic [4:0]                 flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int FW   = MAN_W + 8;
  localparam int EW   = EXP_W + 2;
  localparam int QW   = MAN_W + 3;
  localparam int RW   = 2 * MAN_W + 6;

  localparam logic [FP_MAX_W-1:0] QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic [FP_MAX_W-1:0] INF_WIDE  = fp_inf(EXP_W, MAN_W);
  localparam logic [W-1:0]        QNAN      = QNAN_WIDE[W-1:0];
  localparam logic [W-2:0]        INF_MAG   = INF_WIDE[W-2:0];

  localparam logic [EW-1:0]        BIAS_E    = EW'(BIAS);
  localparam logic [EW-1:0]        E_ONE     = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] E_OVF     = EW'((32'sd1 <<< EXP_W) - 32'sd1);
  localparam logic [QW-1:0]        Q_ONE     = {{(QW-1){1'b0}}, 1'b1};
  localparam logic [FW+1:0]        TWO_Q     = {2'b10, {FW{1'b0}}};
  localparam logic [1:0]           LAST_ITER = 2'(NR_ITERS - 1);

  state_e                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [W-1:0]           result_q, result_d;
  fp_flags_t              flags_q, flags_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   e_q, e_d;
  logic [FW:0]            x_q, x_d;
  logic [FW+1:0]          t_q, t_d;
  logic [QW-1:0]          q_q, q_d;
  logic                   sticky_q, sticky_d;
  logic [1:0]             iter_q, iter_d;

  function automatic op_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    op_class_e c;
    if (e == {EXP_W{1'b0}}) begin
      c = C_ZERO;
    end else if (e == {EXP_W{1'b1}}) begin
      c = (f == {MAN_W{1'b0}}) ? C_INF : C_NAN;
    end else begin
      c = C_NORM;
    end
    return c;
  endfunction

  logic [EXP_W-1:0]   exp_a_s, exp_b_s;
  logic [MAN_W:0]     ma_s, mb_s;
  logic [FW:0]        d_s, seed_s;
  op_class_e          cls_a_s, cls_b_s;
  logic               sign_s;

  assign exp_a_s = a_q[W-2:MAN_W];
  assign exp_b_s = b_q[W-2:MAN_W];
  assign ma_s    = {1'b1, a_q[MAN_W-1:0]};
  assign mb_s    = {1'b1, b_q[MAN_W-1:0]};
  assign d_s     = {mb_s, 8'd0};
  assign cls_a_s = classify(exp_a_s, a_q[MAN_W-1:0]);
  assign cls_b_s = classify(exp_b_s, b_q[MAN_W-1:0]);
  assign sign_s  = a_q[W-1] ^ b_q[W-1];

  fp_recip_seed_lut #(.LUT_BITS(LUT_BITS), .FW(FW)) u_seed (
    .idx  (b_q[MAN_W-1 -: LUT_BITS]),
    .seed (seed_s)
  );

  logic [2*FW+1:0]       prod_dx_s;
  logic [2*FW+2:0]       prod_xt_s;
  logic [MAN_W+FW+1:0]   prod_q_s;
  logic [2*MAN_W+3:0]    qmb_s;
  logic [RW-1:0]         rem_s, mb_ext_s;
  logic [MAN_W:0]        mant_s;
  logic [MAN_W+1:0]      sum_s;
  logic                  round_up_s, carry_s;
  logic [MAN_W-1:0]      frac_r_s;
  logic signed [EW-1:0]  e_round_s;
  logic                  unused_bits_s;

  // Shared datapath: NR products, exact remainder and rounding of the current q
  always_comb begin
    prod_dx_s  = {{(FW+1){1'b0}}, d_s} * {{(FW+1){1'b0}}, x_q};
    prod_xt_s  = {{(FW+2){1'b0}}, x_q} * {{(FW+1){1'b0}}, t_q};
    prod_q_s   = {{(FW+1){1'b0}}, ma_s} * {{(MAN_W+1){1'b0}}, x_q};
    qmb_s      = {{(MAN_W+1){1'b0}}, q_q} * {{QW{1'b0}}, mb_s};
    rem_s      = {3'b000, ma_s, {(MAN_W+2){1'b0}}} - {2'b00, qmb_s};
    mb_ext_s   = {{(MAN_W+5){1'b0}}, mb_s};
    mant_s     = q_q[QW-1:2];
    round_up_s = q_q[1] & (q_q[0] | sticky_q | mant_s[0]);
    sum_s      = {1'b0, mant_s} + {{(MAN_W+1){1'b0}}, round_up_s};
    carry_s    = sum_s[MAN_W+1];
    frac_r_s   = carry_s ? sum_s[MAN_W:1] : sum_s[MAN_W-1:0];
    e_round_s  = e_q + {{(EW-1){1'b0}}, carry_s};
  end

  assign unused_bits_s = ^{prod_dx_s[FW-1:0], prod_xt_s[2*FW+2], prod_xt_s[FW-1:0],
                           prod_q_s[MAN_W+FW+1], prod_q_s[FW-3:0]};

  // Next-state and next-output logic for the whole sequencer
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    e_d         = e_q;
    x_d         = x_q;
    t_d         = t_q;
    q_d         = q_q;
    sticky_d    = sticky_q;
    iter_d      = iter_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          in_ready_d = 1'b0;
          state_d    = S_CLASSIFY;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_CLASSIFY: begin
        sign_d = sign_s;
        e_d    = {2'b00, exp_a_s} - {2'b00, exp_b_s} + BIAS_E;
        if (cls_a_s == C_NAN || cls_b_s == C_NAN) begin
          result_d = QNAN;
          flags_d  = FP_FLAGS_NONE;
        end else if ((cls_a_s == C_ZERO && cls_b_s == C_ZERO) ||
                     (cls_a_s == C_INF && cls_b_s == C_INF)) begin
          result_d        = QNAN;
          flags_d         = FP_FLAGS_NONE;
          flags_d.invalid = 1'b1;
        end else if (cls_a_s == C_NORM && cls_b_s == C_ZERO) begin
          result_d            = {sign_s, INF_MAG};
          flags_d             = FP_FLAGS_NONE;
          flags_d.div_by_zero = 1'b1;
        end else if (cls_a_s == C_INF) begin
          result_d = {sign_s, INF_MAG};
          flags_d  = FP_FLAGS_NONE;
        end else if (cls_b_s == C_INF || cls_a_s == C_ZERO) begin
          result_d = {sign_s, {(W-1){1'b0}}};
          flags_d  = FP_FLAGS_NONE;
        end else begin
          result_d = result_q;
        end
        if (cls_a_s == C_NORM && cls_b_s == C_NORM) begin
          state_d = S_SEED;
        end else begin
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_SEED: begin
        x_d     = seed_s;
        iter_d  = 2'd0;
        state_d = S_MUL_DX;
      end
      S_MUL_DX: begin
        t_d     = prod_dx_s[2*FW+1:FW];
        state_d = S_SUB;
      end
      S_SUB: begin
        t_d     = TWO_Q - t_q;
        state_d = S_MUL_X;
      end
      S_MUL_X: begin
        x_d = prod_xt_s[2*FW:FW];
        if (iter_q == LAST_ITER) begin
          state_d = S_QUOT;
        end else begin
          iter_d  = iter_q + 2'd1;
          state_d = S_MUL_DX;
        end
      end
      S_QUOT: begin
        q_d     = prod_q_s[FW+MAN_W:FW-2];
        state_d = S_CORR;
      end
      S_CORR: begin
        // The truncated estimate is within one unit of floor; the remainder says which way.
        if (rem_s[RW-1]) begin
          q_d      = q_q - Q_ONE;
          sticky_d = (rem_s + mb_ext_s) != {RW{1'b0}};
        end else if (rem_s >= mb_ext_s) begin
          q_d      = q_q + Q_ONE;
          sticky_d = (rem_s - mb_ext_s) != {RW{1'b0}};
        end else begin
          sticky_d = rem_s != {RW{1'b0}};
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (!q_q[QW-1]) begin
          q_d = {q_q[QW-2:0], 1'b0};
          e_d = e_q - E_ONE;
        end else begin
          q_d = q_q;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        flags_d = FP_FLAGS_NONE;
        if (e_round_s >= E_OVF) begin
          result_d         = {sign_q, INF_MAG};
          flags_d.overflow = 1'b1;
          flags_d.inexact  = 1'b1;
        end else if (e_round_s[EW-1] || e_round_s == {EW{1'b0}}) begin
          result_d          = {sign_q, {(W-1){1'b0}}};
          flags_d.underflow = 1'b1;
          flags_d.inexact   = 1'b1;
        end else begin
          result_d        = {sign_q, e_round_s[EXP_W-1:0], frac_r_s};
          flags_d.inexact = q_q[1] | q_q[0] | sticky_q;
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          result_d    = {W{1'b0}};
          flags_d     = FP_FLAGS_NONE;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        result_d    = {W{1'b0}};
        flags_d     = FP_FLAGS_NONE;
        in_ready_d  = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {W{1'b0}};
      flags_q     <= FP_FLAGS_NONE;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      sign_q      <= 1'b0;
      e_q         <= {EW{1'b0}};
      x_q         <= {(FW+1){1'b0}};
      t_q         <= {(FW+2){1'b0}};
      q_q         <= {QW{1'b0}};
      sticky_q    <= 1'b0;
      iter_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      e_q         <= e_d;
      x_q         <= x_d;
      t_q         <= t_d;
      q_q         <= q_d;
      sticky_q    <= sticky_d;
      iter_q      <= iter_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_nr_divider.sv
// Directed-vector and random-pair bench for fp_nr_divider at binary32.
module tb_fp_nr_divider;
  import fp_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_nr_divider dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vr, input logic [4:0] vf, input int vl);
    vec_t v;
    v.name = n; v.a = va; v.b = vb; v.res = vr; v.fl = vf; v.lat = vl;
    vecs.push_back(v);
  endtask

  // Correctly rounded RNE reference for normal binary32 operands: {flags, result}
  function automatic logic [36:0] model_div(input logic [31:0] x, input logic [31:0] y);
    logic [23:0] mx, my;
    logic [49:0] num, qw, rw;
    logic [25:0] qq;
    logic [24:0] m;
    logic        s, g, r, up, sg;
    int          e;
    mx = {1'b1, x[22:0]};
    my = {1'b1, y[22:0]};
    sg = x[31] ^ y[31];
    e  = int'(x[30:23]) - int'(y[30:23]) + 127;
    if (mx < my) begin
      num = {mx, 26'd0};
      e   = e - 1;
    end else begin
      num = {1'b0, mx, 25'd0};
    end
    qw = num / {26'd0, my};
    rw = num % {26'd0, my};
    qq = qw[25:0];
    s  = (rw != 50'd0);
    g  = qq[1];
    r  = qq[0];
    up = g & (r | s | qq[2]);
    m  = {1'b0, qq[25:2]} + {24'd0, up};
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {5'b00101, sg, 8'hFF, 23'd0};
    if (e <= 0)   return {5'b00011, sg, 31'd0};
    return {4'b0000, g | r | s, sg, e[7:0], m[22:0]};
  endfunction

  // One full transaction; inputs are scrambled after the accept edge.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                       output logic [31:0] res, output logic [4:0] fl, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: in_ready=%b, required 1", in_ready);
    end
    a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom(); b = $urandom();
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 64);
    res = result;
    fl  = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [4:0]  fl;
    logic [36:0] exp_m;
    logic [31:0] ra, rb;
    int          lat;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_flags", {59'd0, flags}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    add_vec("six_by_two",    32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 12);
    add_vec("one_third",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 12);
    add_vec("zero_zero",     32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000, 1);
    add_vec("one_by_zero",   32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
    add_vec("one_by_mzero",  32'h3F800000, 32'h80000000, 32'hFF800000, 5'b01000, 1);
    add_vec("overflow",      32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 12);
    add_vec("ovf_e255",      32'h7F7FFFFF, 32'h3F7FFFFF, 32'h7F800000, 5'b00101, 12);
    add_vec("underflow",     32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 12);
    add_vec("min_normal",    32'h00800000, 32'h3F800000, 32'h00800000, 5'b00000, 12);
    add_vec("ten_by_five",   32'h41200000, 32'h40A00000, 32'h40000000, 5'b00000, 12);
    add_vec("neg_2p5",       32'hC0A00000, 32'h40000000, 32'hC0200000, 5'b00000, 12);
    add_vec("one_by_one",    32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 12);
    add_vec("nan_operand",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000, 1);
    add_vec("inf_by_inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 1);
    add_vec("ninf_by_one",   32'hFF800000, 32'h3F800000, 32'hFF800000, 5'b00000, 1);
    add_vec("inf_by_zero",   32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 1);
    add_vec("one_by_inf",    32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 1);
    add_vec("mzero_by_one",  32'h80000000, 32'h3F800000, 32'h80000000, 5'b00000, 1);
    add_vec("subnorm_by_one",32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].a, vecs[i].b, res, fl, lat);
      chk({vecs[i].name, "_result"}, {32'd0, res}, {32'd0, vecs[i].res});
      chk({vecs[i].name, "_flags"}, {59'd0, fl}, {59'd0, vecs[i].fl});
      chk({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      chk({vecs[i].name, "_released"}, {62'd0, out_valid, in_ready}, 64'd1);
    end

    // Random normal pairs against the reference model
    for (int i = 0; i < 1500; i++) begin
      ra = {$urandom_range(1, 0), 8'($urandom_range(254, 1)), 23'($urandom())};
      rb = {$urandom_range(1, 0), 8'($urandom_range(190, 64)), 23'($urandom())};
      if (i % 7 == 0) rb[22:0] = 23'h7FFFFF;
      exp_m = model_div(ra, rb);
      do_op(ra, rb, res, fl, lat);
      chk($sformatf("rand_%0d_%h_%h", i, ra, rb), {27'd0, fl, res}, {27'd0, exp_m});
      chk($sformatf("rand_%0d_latency", i), 64'(lat), 64'd12);
    end

    // Output hold under back-pressure, then back-to-back accept
    a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 64);
    chk("hold_latency", 64'(lat), 64'd12);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_%0d_result", k), {32'd0, result}, 64'h3EAAAAAB);
      chk($sformatf("hold_%0d_flags", k), {59'd0, flags}, 64'd1);
      chk($sformatf("hold_%0d_valid_ready", k), {62'd0, out_valid, in_ready}, 64'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_hs_cleared", {27'd0, out_valid, flags, result}, 64'd0);
    chk("after_hs_in_ready", {63'd0, in_ready}, 64'd1);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_accepted", {63'd0, in_ready}, 64'd0);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 64);
    chk("b2b_latency", 64'(lat), 64'd12);
    chk("b2b_result", {32'd0, result}, 64'h40400000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the second NR iteration
    a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {26'd0, in_ready, out_valid, flags, result}, 64'd0);
    chk("midrst_state", 64'(dut.state_q), 64'(S_IDLE));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    do_op(32'h41200000, 32'h40A00000, res, fl, lat);
    chk("post_rst_result", {27'd0, fl, res}, 64'h40000000);
    chk("post_rst_latency", 64'(lat), 64'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
